dmem_responder: RTL and testbench

- Data-memory responder at the far end of the MEM stage's load/store request interface.
- Accepts one load or store request at a time from the pipeline and services it against an internal little-endian byte-addressed scratchpad.
- Returns a response after a fixed, parameterised latency, carrying loaded data, the destination register tag and an error flag.
- Provides the backpressure (req_ready) the MEM stage uses to generate its stall.

---
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store against a
// little-endian byte-addressed scratchpad, answered after a fixed latency.
module dmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    input  logic [5:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_load,
    output logic [63:0] rsp_rdata,
    output logic [5:0]  rsp_rd,
    output logic        rsp_error,
    output logic        busy
);

    localparam int         WORDS     = 2 ** (ADDR_WIDTH - 3);
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_next;
    logic [3:0] counter, counter_next;

    logic [63:0] mem [WORDS];

    logic                  accept;
    logic [ADDR_WIDTH-4:0] word_idx;
    logic [2:0]            lane;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  access_error;
    logic [63:0]           rd_word;
    logic [63:0]           shifted;
    logic [63:0]           load_value;
    logic [7:0]            byte_mask;
    logic [7:0]            byte_en;
    logic [63:0]           wdata_shifted;

    assign accept   = req_valid && req_ready && !reset;
    assign word_idx = req_addr[ADDR_WIDTH-1:3];
    assign lane     = req_addr[2:0];

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'd0);
            default: misaligned = (req_addr[2:0] != 3'd0);
        endcase
    end

    assign out_of_range = (req_addr[63:ADDR_WIDTH] != '0);
    assign access_error = misaligned || out_of_range;

    // Loads are fully resolved at the accept edge so later req_* changes cannot leak in.
    assign rd_word = mem[word_idx];
    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        load_value = shifted;
        case (req_size)
            2'd0: load_value = req_unsigned ? {56'd0, shifted[7:0]}
                                            : {{56{shifted[7]}}, shifted[7:0]};
            2'd1: load_value = req_unsigned ? {48'd0, shifted[15:0]}
                                            : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: load_value = req_unsigned ? {32'd0, shifted[31:0]}
                                            : {{32{shifted[31]}}, shifted[31:0]};
            default: load_value = shifted;
        endcase
    end

    always_comb begin
        byte_mask = 8'hFF;
        case (req_size)
            2'd0:    byte_mask = 8'h01;
            2'd1:    byte_mask = 8'h03;
            2'd2:    byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
    end

    assign byte_en       = byte_mask << lane;
    assign wdata_shifted = req_wdata << {lane, 3'b000};

    // Scratchpad contents survive reset; a store commits on its accept edge.
    always_ff @(posedge clk) begin
        if (accept && !req_load && !access_error) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_shifted[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= 4'd0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next   = WAIT;
                        counter_next = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                counter_next = counter - 4'd1;
                if (counter == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_load  <= 1'b0;
            rsp_rdata <= 64'd0;
            rsp_rd    <= 6'd0;
            rsp_error <= 1'b0;
        end else if (accept) begin
            rsp_load  <= req_load;
            rsp_rd    <= req_rd;
            rsp_error <= access_error;
            rsp_rdata <= (req_load && !access_error) ? load_value : 64'd0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, multi-cycle corner
// sequences and randomized traffic checked against a byte-array reference model.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_load, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [5:0]  req_rd;
    logic        rsp_valid, rsp_ready, rsp_load, rsp_error, busy;
    logic [63:0] rsp_rdata;
    logic [5:0]  rsp_rd;

    logic        l1_req_valid, l1_req_ready, l1_req_load, l1_req_unsigned;
    logic [63:0] l1_req_addr, l1_req_wdata;
    logic [1:0]  l1_req_size;
    logic [5:0]  l1_req_rd;
    logic        l1_rsp_valid, l1_rsp_ready, l1_rsp_load, l1_rsp_error, l1_busy;
    logic [63:0] l1_rsp_rdata;
    logic [5:0]  l1_rsp_rd;

    dmem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_load(rsp_load),
        .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_error(rsp_error), .busy(busy)
    );

    dmem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_load(l1_req_load),
        .req_addr(l1_req_addr), .req_size(l1_req_size), .req_unsigned(l1_req_unsigned),
        .req_wdata(l1_req_wdata), .req_rd(l1_req_rd),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_load(l1_rsp_load),
        .rsp_rdata(l1_rsp_rdata), .rsp_rd(l1_rsp_rd), .rsp_error(l1_rsp_error), .busy(l1_busy)
    );

    int tests    = 0;
    int failures = 0;
    int cycle    = 0;
    int acc_l2[$];
    int acc_l1[$];
    logic [7:0] model_mem [4096];

    typedef struct {
        logic        ld;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] wdata;
        logic [5:0]  rd;
        logic        err;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs[$];

    // Inputs only change just after a posedge, so this negedge view of accepts is race-free.
    always @(negedge clk) begin
        cycle++;
        if (req_valid && req_ready) acc_l2.push_back(cycle);
        if (l1_req_valid && l1_req_ready) acc_l1.push_back(cycle);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic ld, input logic [63:0] addr, input logic [1:0] size,
                                input logic uns, input logic [63:0] wdata, input logic [5:0] rd,
                                input logic err, input logic [63:0] rdata);
        vec_t v;
        v.ld = ld; v.addr = addr; v.size = size; v.uns = uns;
        v.wdata = wdata; v.rd = rd; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelOp(input logic ld, input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] wdata,
                           output logic err, output logic [63:0] rdata);
        int n;
        int a;
        logic [63:0] v;
        n = 1 << size;
        err = (addr >= 64'd4096) || ((addr % 64'(n)) != 64'd0);
        rdata = 64'd0;
        if (!err) begin
            a = int'(addr[11:0]);
            if (!ld) begin
                for (int i = 0; i < n; i++) model_mem[a + i] = wdata[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < n; i++) v = v | (64'(model_mem[a + i]) << (8 * i));
                if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                rdata = v;
            end
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [63:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [63:0] wdata, input logic [5:0] rd);
        logic ok;
        ok = 1'b0;
        req_valid = 1'b1; req_load = ld; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata; req_rd = rd;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        // Scramble the request bus: the in-flight operation must use captured values.
        req_valid = 1'b0; req_load = 1'($urandom); req_addr = {$urandom, $urandom};
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_wdata = {$urandom, $urandom}; req_rd = 6'($urandom);
        if (!ok) checkOutput("accept timeout", 64'(ok), 64'd1);
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
    endtask

    task automatic releaseRsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic runOp(input string name, input logic ld, input logic [63:0] addr,
                         input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                         input logic [5:0] rd, input logic use_exp, input logic exp_err,
                         input logic [63:0] exp_rdata, input int hold);
        logic m_err;
        logic [63:0] m_rdata;
        int lat;
        modelOp(ld, addr, size, uns, wdata, m_err, m_rdata);
        if (!use_exp) begin
            exp_err = m_err;
            exp_rdata = m_rdata;
        end
        applyStimulus(ld, addr, size, uns, wdata, rd);
        waitValid(lat);
        checkOutput({name, " latency"}, 64'(lat), 64'd2);
        repeat (hold) @(negedge clk);
        checkOutput({name, " rsp_error"}, 64'(rsp_error), 64'(exp_err));
        checkOutput({name, " rsp_rdata"}, rsp_rdata, exp_rdata);
        checkOutput({name, " rsp_rd"}, 64'(rsp_rd), 64'(rd));
        checkOutput({name, " rsp_load"}, 64'(rsp_load), 64'(ld));
        releaseRsp();
    endtask

    initial begin
        int lat;
        logic ok;
        logic [1:0] sz;
        logic [63:0] addr;
        int r;

        reset = 1'b1;
        req_valid = 1'b0; req_load = 1'b0; req_addr = 64'd0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 64'd0; req_rd = 6'd0; rsp_ready = 1'b0;
        l1_req_valid = 1'b0; l1_req_load = 1'b0; l1_req_addr = 64'd0; l1_req_size = 2'd0;
        l1_req_unsigned = 1'b0; l1_req_wdata = 64'd0; l1_req_rd = 6'd0; l1_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset req_ready", 64'(req_ready), 64'd1);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 64'd0);
        checkOutput("reset rsp_rd", 64'(rsp_rd), 64'd0);
        checkOutput("reset rsp_error", 64'(rsp_error), 64'd0);
        checkOutput("reset rsp_load", 64'(rsp_load), 64'd0);
        @(posedge clk);
        #1;

        vecs.push_back(mk(0, 64'h10,   2'd3, 0, 64'h1122334455667788, 6'd1,  0, 64'h0));
        vecs.push_back(mk(1, 64'h10,   2'd3, 0, 64'h0,                6'd2,  0, 64'h1122334455667788));
        vecs.push_back(mk(0, 64'h10,   2'd3, 0, 64'h0,                6'd3,  0, 64'h0));
        vecs.push_back(mk(0, 64'h13,   2'd0, 0, 64'hDEADBEEFCAFE0080, 6'd4,  0, 64'h0));
        vecs.push_back(mk(1, 64'h13,   2'd0, 0, 64'h0,                6'd5,  0, 64'hFFFFFFFFFFFFFF80));
        vecs.push_back(mk(1, 64'h13,   2'd0, 1, 64'h0,                6'd6,  0, 64'h80));
        vecs.push_back(mk(1, 64'h10,   2'd3, 0, 64'h0,                6'd7,  0, 64'h0000000080000000));
        vecs.push_back(mk(1, 64'h21,   2'd1, 0, 64'h0,                6'd8,  1, 64'h0));
        vecs.push_back(mk(1, 64'h102,  2'd2, 0, 64'h0,                6'd9,  1, 64'h0));
        vecs.push_back(mk(0, 64'h0,    2'd3, 0, 64'hCAFEF00DDEADBEEF, 6'd10, 0, 64'h0));
        vecs.push_back(mk(0, 64'h1000, 2'd2, 0, 64'h12345678,         6'd11, 1, 64'h0));
        vecs.push_back(mk(1, 64'h0,    2'd3, 0, 64'h0,                6'd12, 0, 64'hCAFEF00DDEADBEEF));
        vecs.push_back(mk(0, 64'h18,   2'd3, 0, 64'h8899AABBCCDDEEFF, 6'd13, 0, 64'h0));
        vecs.push_back(mk(1, 64'h1C,   2'd1, 0, 64'h0,                6'd14, 0, 64'hFFFFFFFFFFFFAABB));
        vecs.push_back(mk(1, 64'h1C,   2'd2, 1, 64'h0,                6'd15, 0, 64'h000000008899AABB));
        vecs.push_back(mk(1, 64'h18,   2'd2, 0, 64'h0,                6'd16, 0, 64'hFFFFFFFFCCDDEEFF));
        vecs.push_back(mk(0, 64'h1A,   2'd1, 0, 64'hFFFFFFFFFFFF1234, 6'd18, 0, 64'h0));
        vecs.push_back(mk(1, 64'h18,   2'd3, 1, 64'h0,                6'd19, 0, 64'h8899AABB1234EEFF));
        vecs.push_back(mk(1, 64'h13,   2'd3, 0, 64'h0,                6'd20, 1, 64'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].ld, vecs[i].addr, vecs[i].size, vecs[i].uns,
                  vecs[i].wdata, vecs[i].rd, 1'b1, vecs[i].err, vecs[i].rdata, 0);
        end

        // Stalled consumer: response must hold while a competing request is ignored.
        applyStimulus(1'b1, 64'h18, 2'd3, 1'b0, 64'h0, 6'd17);
        waitValid(lat);
        checkOutput("hold latency", 64'(lat), 64'd2);
        req_valid = 1'b1; req_load = 1'b0; req_addr = 64'h18; req_size = 2'd3; req_wdata = 64'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("hold rsp_rd", 64'(rsp_rd), 64'd17);
            checkOutput("hold rsp_rdata", rsp_rdata, 64'h8899AABB1234EEFF);
            checkOutput("hold req_ready", 64'(req_ready), 64'd0);
        end
        #1 req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("release req_ready", 64'(req_ready), 64'd1);
        checkOutput("release rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        runOp("ignored store", 1'b1, 64'h18, 2'd3, 1'b0, 64'h0, 6'd21, 1'b1, 1'b0,
              64'h8899AABB1234EEFF, 0);

        // Throughput with the consumer always ready.
        acc_l2.delete();
        acc_l1.delete();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_load = 1'b1; req_addr = 64'h13; req_size = 2'd0; req_unsigned = 1'b1;
        l1_rsp_ready = 1'b1;
        l1_req_valid = 1'b1; l1_req_load = 1'b0; l1_req_addr = 64'h8; l1_req_size = 2'd0;
        l1_req_wdata = 64'h55; l1_req_rd = 6'd3;
        repeat (12) @(posedge clk);
        #1 req_valid = 1'b0;
        l1_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rsp_ready = 1'b0;
        l1_rsp_ready = 1'b0;
        checkOutput("L2 accept count", 64'(acc_l2.size() >= 4), 64'd1);
        for (int i = 1; i < acc_l2.size() && i < 4; i++)
            checkOutput("L2 accept spacing", 64'(acc_l2[i] - acc_l2[i-1]), 64'd3);
        checkOutput("L1 accept count", 64'(acc_l1.size() >= 4), 64'd1);
        for (int i = 1; i < acc_l1.size() && i < 4; i++)
            checkOutput("L1 accept spacing", 64'(acc_l1[i] - acc_l1[i-1]), 64'd2);

        l1_req_valid = 1'b1; l1_req_load = 1'b1; l1_req_addr = 64'h8; l1_req_size = 2'd0;
        l1_req_unsigned = 1'b1; l1_req_rd = 6'd9;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (l1_req_ready) begin
                @(posedge clk);
                #1 ok = 1'b1;
            end
        end
        l1_req_valid = 1'b0; l1_req_addr = 64'h0;
        checkOutput("L1 accept", 64'(ok), 64'd1);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (l1_rsp_valid) break;
        end
        checkOutput("L1 latency", 64'(lat), 64'd1);
        checkOutput("L1 rsp_rdata", l1_rsp_rdata, 64'h55);
        checkOutput("L1 rsp_rd", 64'(l1_rsp_rd), 64'd9);
        l1_rsp_ready = 1'b1;
        @(posedge clk);
        #1 l1_rsp_ready = 1'b0;

        // Reset while a store is waiting: store stays committed, response is dropped.
        begin
            logic e;
            logic [63:0] d;
            modelOp(1'b0, 64'h40, 2'd0, 1'b0, 64'hAB, e, d);
        end
        applyStimulus(1'b0, 64'h40, 2'd0, 1'b0, 64'hAB, 6'd30);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset req_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no response after reset", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        runOp("load after reset", 1'b1, 64'h40, 2'd0, 1'b0, 64'h0, 6'd31, 1'b1, 1'b0,
              64'hFFFFFFFFFFFFFFAB, 0);

        for (int i = 0; i < 32; i++) begin
            runOp("rand init", 1'b0, 64'h200 + 64'(8 * i), 2'd3, 1'b0, {$urandom, $urandom},
                  6'($urandom), 1'b0, 1'b0, 64'h0, 0);
        end
        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom);
            r = int'($urandom % 10);
            if (r == 0) begin
                addr = {$urandom, $urandom};
                addr[63] = 1'b1;
            end else if (r == 1) begin
                addr = 64'h200 + 64'($urandom % 256);
            end else begin
                addr = 64'h200 + (64'($urandom % 256) & ~((64'd1 << sz) - 64'd1));
            end
            runOp("random", 1'($urandom), addr, sz, 1'($urandom), {$urandom, $urandom},
                  6'($urandom), 1'b0, 1'b0, 64'h0, int'($urandom % 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
